// File: rtl/crossbar_arb_pkg.sv
// -----------------------------------------------------------------------------
// crossbar_arb_pkg
// Shared types and sizing helpers for the crossbar output arbiters.
//   arb_state_t  : arbiter ownership state (IDLE = no owner, BUSY = locked).
//   calc_idw()   : width of a requester index for N requesters (at least 1).
//   calc_cw()    : width of a beat counter that must hold 0..MAX_BEATS (at least 1).
//   onehot2idx() : binary index of a one-hot vector (0 for an all-zero vector).
// -----------------------------------------------------------------------------
package crossbar_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Widest one-hot vector onehot2idx accepts; callers zero-extend.
    localparam int ONEHOT_MAX_W = 64;

    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_cw(input int max_beats);
        return (max_beats <= 1) ? 1 : $clog2(max_beats + 1);
    endfunction

    // OR-ing the indices of the set bits is exact for a one-hot input and
    // needs no priority chain.
    function automatic int unsigned onehot2idx(input logic [ONEHOT_MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin pick: searches req starting at index ptr and
// moving upward, wrapping modulo N; the first set bit wins.
// Ports:
//   req       [N]   request vector
//   ptr       [IDW] index where the search starts (must be < N)
//   win_id    [IDW] index of the winning requester (0 when none)
//   win_valid [1]   at least one request is set
// -----------------------------------------------------------------------------
module rr_priority_pick
    import crossbar_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = calc_idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] win_id,
    output logic           win_valid
);

    // cand_id[k] is the requester visited k-th in the search order; rot[k]
    // is its request bit. The wrap is an explicit subtraction of N so that a
    // non-power-of-two N never relies on bit-width overflow.
    logic [IDW-1:0] cand_id [N];
    logic [N-1:0]   rot;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IDW:0] sum;
        assign sum         = {1'b0, ptr} + (IDW+1)'(gi);
        assign cand_id[gi] = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
        assign rot[gi]     = req[cand_id[gi]];
    end

    // Scan from the far end so the lowest search position is written last.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_valid = 1'b1;
                win_id    = cand_id[k];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// rr_arbiter_lock
// Round-robin arbiter for one crossbar output. A grant is held for a whole
// packet (until the owner's last beat), for at most MAX_BEATS accepted beats
// (0 = unlimited), or until the owner drops its request. On release the next
// owner is picked in the same cycle, so handover has no bubble.
// Ports:
//   clock       [1]   rising-edge clock
//   reset_n     [1]   asynchronous active-low reset
//   request     [N]   per-requester request, held high for the whole packet
//   last        [N]   per-requester end-of-packet flag, qualified by a beat
//   ready       [1]   downstream accepts the current beat
//   grant       [N]   registered one-hot grant (or zero)
//   grant_id    [IDW] binary index of the owner (0 when no grant)
//   grant_valid [1]   OR of grant
//   beat_cnt    [CW]  beats accepted in the current grant
// -----------------------------------------------------------------------------
module rr_arbiter_lock
    import crossbar_arb_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MAX_BEATS = 16,
    parameter  int IDW       = calc_idw(N),
    localparam int CW        = calc_cw(MAX_BEATS)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [N-1:0]   request,
    input  logic [N-1:0]   last,
    input  logic           ready,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic [CW-1:0]  beat_cnt
);

    localparam logic [CW-1:0] CNT_MAX = (MAX_BEATS == 0) ? {CW{1'b1}} : CW'(MAX_BEATS);

    arb_state_t     state_reg;
    logic [IDW-1:0] ptr_reg;
    logic [N-1:0]   grant_reg;
    logic [IDW-1:0] grant_id_reg;
    logic [CW-1:0]  beat_cnt_reg;

    logic [IDW-1:0] win_id;
    logic           win_valid;
    logic [IDW-1:0] ptr_next;
    logic           owner_req;
    logic           owner_last;
    logic           beat;
    logic [CW:0]    cnt_plus1;
    logic           quota_hit;
    logic           release_now;

    // The pick always uses the registered pointer; in BUSY that pointer is
    // already one past the owner, so the owner is searched last and only
    // wins again when nobody else is requesting.
    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req       (request),
        .ptr       (ptr_reg),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    assign owner_req  = request[grant_id_reg];
    assign owner_last = last[grant_id_reg];
    assign beat       = (state_reg == BUSY) && owner_req && ready;
    assign cnt_plus1  = {1'b0, beat_cnt_reg} + (CW+1)'(1);
    assign quota_hit  = (MAX_BEATS != 0) && beat && (cnt_plus1 == (CW+1)'(MAX_BEATS));

    // Dropping the request releases even while stalled; last and quota only
    // release on an accepted beat.
    assign release_now = (state_reg == BUSY) &&
                         ((beat && owner_last) || quota_hit || !owner_req);

    assign ptr_next = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
        end else if (state_reg == IDLE || release_now) begin
            beat_cnt_reg <= '0;
            if (win_valid) begin
                state_reg    <= BUSY;
                grant_reg    <= N'(1) << win_id;
                grant_id_reg <= win_id;
                ptr_reg      <= ptr_next;
            end else begin
                state_reg    <= IDLE;
                grant_reg    <= '0;
                grant_id_reg <= '0;
            end
        end else if (beat && (beat_cnt_reg != CNT_MAX)) begin
            beat_cnt_reg <= beat_cnt_reg + CW'(1);
        end
    end

    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = |grant_reg;
    assign beat_cnt    = beat_cnt_reg;

endmodule
